// File: rtl/fp_add_seq_ctrl_if.sv
// Operand/result handshake bundle for the small-float adder sequencer.
interface fp_add_seq_ctrl_if #(
    parameter int unsigned DATA_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_z;
    logic              out_ovf;
    logic              out_unf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_z, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_z, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle sequencer for the 12-bit small-float adder:
// swap, exponent compare, alignment, add/sub, normalisation, exponent limits.
// Optional build macro FPADD_FAST_ALIGN_EN: alignment done in one barrel-shift cycle.
module fp_add_seq_ctrl #(
    parameter int unsigned EXP_W = 4,
    parameter int unsigned MAN_W = 7,
    parameter int unsigned BIAS  = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    fp_add_seq_ctrl_if.slave bus,
    output logic             busy
);

    localparam int unsigned DATA_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned SUM_W   = MAN_W + 2;
    localparam int unsigned D_MAX   = MAN_W + 2;
    localparam int unsigned D_W     = $clog2(D_MAX + 1);
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    localparam logic [EXP_W-1:0] D_MAX_E  = EXP_W'(D_MAX);
    localparam logic [EXP_W:0]   EXP_TOP  = (EXP_W + 1)'(EXP_MAX);
    localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W + 1)'(1);

    // Only the symmetric bias of the exponent field is supported.
    if (BIAS != (1 << (EXP_W - 1)) - 1) begin : g_bias_chk
        $error("fp_add_seq_ctrl: unsupported exponent bias");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [SIG_W-1:0]    sig_l_q, sig_l_d, sig_s_q, sig_s_d;
    logic                sign_q, sign_d;
    logic                eff_sub_q, eff_sub_d;
    logic [EXP_W:0]      exp_q, exp_d;
    logic [D_W-1:0]      d_q, d_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   z_q, z_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;

    // Operand decode and magnitude ordering (used in PREP).
    logic                sa, sb;
    logic [EXP_W-1:0]    ea, eb, e_l, e_s, e_diff;
    logic [MAN_W-1:0]    fa, fb;
    logic [SIG_W-1:0]    sig_a, sig_b;
    logic                a_ge_b;
    logic [D_W-1:0]      d_prep;

    // Split operands, zero the significand of zero-exponent inputs, pick L/S.
    always_comb begin
        sa     = a_q[DATA_W-1];
        sb     = b_q[DATA_W-1];
        ea     = a_q[DATA_W-2 -: EXP_W];
        eb     = b_q[DATA_W-2 -: EXP_W];
        fa     = a_q[MAN_W-1:0];
        fb     = b_q[MAN_W-1:0];
        sig_a  = (ea == '0) ? '0 : {1'b1, fa};
        sig_b  = (eb == '0) ? '0 : {1'b1, fb};
        a_ge_b = {ea, sig_a[MAN_W-1:0]} >= {eb, sig_b[MAN_W-1:0]};
        e_l    = a_ge_b ? ea : eb;
        e_s    = a_ge_b ? eb : ea;
        e_diff = e_l - e_s;
        d_prep = (e_diff > D_MAX_E) ? D_W'(D_MAX) : D_W'(e_diff);
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sig_l_d   = sig_l_q;
        sig_s_d   = sig_s_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        d_d       = d_q;
        sum_d     = sum_q;
        z_d       = z_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = PREP;
                end
            end
            PREP: begin
                sig_l_d   = a_ge_b ? sig_a : sig_b;
                sig_s_d   = a_ge_b ? sig_b : sig_a;
                sign_d    = a_ge_b ? sa : sb;
                eff_sub_d = sa ^ sb;
                exp_d     = {1'b0, e_l};
                d_d       = d_prep;
                state_d   = (d_prep != '0) ? ALIGN : ADD;
            end
            ALIGN: begin
`ifdef FPADD_FAST_ALIGN_EN
                sig_s_d = sig_s_q >> d_q;
                d_d     = '0;
                state_d = ADD;
`else
                sig_s_d = sig_s_q >> 1;
                d_d     = d_q - D_W'(1);
                if (d_q == D_W'(1)) begin
                    state_d = ADD;
                end
`endif
            end
            ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                                    : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
                state_d = NORM;
            end
            NORM: begin
                if (sum_q[SUM_W-1]) begin
                    if (exp_q >= EXP_TOP) begin
                        z_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        sum_d = sum_q >> 1;
                        exp_d = exp_q + EXP_ONE;
                    end
                end else if ((sum_q != '0) && !sum_q[SUM_W-2]) begin
                    if (exp_q <= EXP_ONE) begin
                        z_d     = '0;
                        unf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        sum_d = sum_q << 1;
                        exp_d = exp_q - EXP_ONE;
                    end
                end else begin
                    z_d     = (sum_q == '0) ? '0
                                            : {sign_q, exp_q[EXP_W-1:0], sum_q[MAN_W-1:0]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sig_l_q     <= '0;
            sig_s_q     <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= '0;
            d_q         <= '0;
            sum_q       <= '0;
            z_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sig_l_q     <= sig_l_d;
            sig_s_q     <= sig_s_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            d_q         <= d_d;
            sum_q       <= sum_d;
            z_q         <= z_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_z     = z_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_unf   = unf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed bench for fp_add_seq_ctrl: values, flags, latency, backpressure, reset abort.
module tb_fp_add_seq_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    fp_add_seq_ctrl_if ifc ();

    fp_add_seq_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FPADD_FAST_ALIGN_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // Issue one operation and wait (bounded) for out_valid; check result and latency.
    task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] ez, input logic eo, input logic eu, input int elat);
        int lat;
        bit seen;
        @(negedge clk);
        check_eq({tag, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ifc.out_valid) seen = 1'b1;
        end
        check_eq({tag, "_valid"}, 32'(seen), 32'd1);
        check_eq({tag, "_z"}, 32'(ifc.out_z), 32'(ez));
        check_eq({tag, "_ovf"}, 32'(ifc.out_ovf), 32'(eo));
        check_eq({tag, "_unf"}, 32'(ifc.out_unf), 32'(eu));
        check_eq({tag, "_no_reaccept"}, 32'(ifc.in_ready), 32'd0);
        if (elat > 0) check_eq({tag, "_latency"}, 32'(lat), 32'(elat));
        if (ifc.out_ready) begin
            @(posedge clk);
            #1;
            check_eq({tag, "_ready_back"}, 32'(ifc.in_ready), 32'd1);
            check_eq({tag, "_valid_drop"}, 32'(ifc.out_valid), 32'd0);
        end
    endtask

    initial begin
        bit stable;
        bit leaked;
        logic [11:0] z_hold;

        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("rst_out_z", 32'(ifc.out_z), 32'd0);
        check_eq("rst_flags", {30'd0, ifc.out_ovf, ifc.out_unf}, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1.0 + 1.0 = 2.0
        run_op("one_plus_one", 12'h380, 12'h380, 12'h400, 1'b0, 1'b0, 4);
        // 1.0 + -1.0 = +0
        run_op("cancel", 12'h380, 12'hB80, 12'h000, 1'b0, 1'b0, 3);
        // 1.5 + 0.25 = 1.75, d=2
        run_op("align2", 12'h3C0, 12'h280, 12'h3E0, 1'b0, 1'b0, FAST ? 4 : 5);
        // 1.5 + 1.5 = 3.0, right normalise
        run_op("carry", 12'h3C0, 12'h3C0, 12'h440, 1'b0, 1'b0, 4);
        // 2.0 + -1.0 = 1.0, one align and one left shift
        run_op("sub_norm", 12'h400, 12'hB80, 12'h380, 1'b0, 1'b0, 5);
        // 0 + 1.5: zero operand is the smaller one
        run_op("zero_a", 12'h000, 12'h3C0, 12'h3C0, 1'b0, 1'b0, FAST ? 4 : 10);
        // 8.0 + 2^-6: d clamps to 9, small operand vanishes
        run_op("d_clamp", 12'h500, 12'h080, 12'h500, 1'b0, 1'b0, FAST ? 4 : 12);
        // overflow saturates
        run_op("ovf", 12'h7FF, 12'h7FF, 12'h7FF, 1'b1, 1'b0, 0);
        // underflow flushes; larger-magnitude B sets the sign internally
        run_op("unf", 12'h080, 12'h881, 12'h000, 1'b0, 1'b1, 3);
        // flags clear on next accept
        run_op("flag_clear", 12'h380, 12'h380, 12'h400, 1'b0, 1'b0, 4);

        // Backpressure: hold the result for 10 cycles.
        ifc.out_ready = 1'b0;
        run_op("bp", 12'h3C0, 12'h280, 12'h3E0, 1'b0, 1'b0, FAST ? 4 : 5);
        z_hold = ifc.out_z;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!ifc.out_valid || ifc.out_z !== z_hold || ifc.in_ready) stable = 1'b0;
        end
        check_eq("bp_stable", 32'(stable), 32'd1);
        check_eq("bp_z_value", 32'(z_hold), 32'h3E0);
        @(negedge clk);
        ifc.out_ready = 1'b1;
        check_eq("bp_no_early_ready", 32'(ifc.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("bp_ready_after", 32'(ifc.in_ready), 32'd1);
        check_eq("bp_busy_after", 32'(busy), 32'd0);

        // Reset during ALIGN aborts the operation.
        @(negedge clk);
        ifc.in_a     = 12'h3C0;
        ifc.in_b     = 12'h280;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_busy_align", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_in_ready", 32'(ifc.in_ready), 32'd1);
        check_eq("abort_out_valid", 32'(ifc.out_valid), 32'd0);
        check_eq("abort_out_z", 32'(ifc.out_z), 32'd0);
        check_eq("abort_flags", {30'd0, ifc.out_ovf, ifc.out_unf}, 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (ifc.out_valid || busy) leaked = 1'b1;
        end
        check_eq("abort_no_result", 32'(leaked), 32'd0);
        run_op("post_reset", 12'h380, 12'h380, 12'h400, 1'b0, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_add_seq_ctrl.md
Name: fp_add_seq_ctrl

Overview:
- Multi-cycle sequencer for the small-float adder path: operand swap, exponent compare, mantissa alignment, add/subtract, normalisation and exponent generation.
- Each operation runs as an FSM with valid/ready handshakes on input and output.
- Sits between the register-file/operand source and the result writeback.
- Format is 12-bit: sign[11], exponent[10:7] (bias 7), fraction[6:0] with hidden 1. Exponent 0 means zero; there are no denormals, inf or NaN.

Parameters:
EXP_W, 4, exponent width
MAN_W, 7, stored fraction width
BIAS, 7, exponent bias (only defaults are verified)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  12  operand A
in_b  input  12  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_z  output  12  sum A+B
out_ovf  output  1  overflow, result saturated
out_unf  output  1  underflow, result flushed to zero
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: reset_n low at a clk edge forces IDLE. in_ready=1, out_valid=0, out_z=0, out_ovf=0, out_unf=0, busy=0. Reset aborts any operation in flight; its result is discarded and never presented.
- States: IDLE, PREP, ALIGN, ADD, NORM, DONE.
- IDLE: in_ready=1. When in_valid=1, latch in_a and in_b, then go to PREP. No other state accepts operands.
- PREP, 1 cycle:
  - Build 8-bit significands {1,frac}; a zero-exponent operand gets significand 0.
  - Order operands so L has the larger magnitude. On equal magnitude, L=A.
  - d = min(Ea-Eb, 9); result sign = sign of L; working exponent = E_L.
  - Next state is ALIGN if d>0, else ADD.
- ALIGN: shift the smaller significand right by 1 each cycle and decrement d. Bits shifted out are discarded (truncation). Go to ADD when d reaches 0.
- ADD, 1 cycle: 9-bit sum = L+S if signs are equal, else L-S. L-S never goes negative.
- NORM: one cycle per shift, plus one terminal cycle.
  - If sum[8]=1: shift right 1, exponent+1.
  - Else if sum≠0 and sum[7]=0: shift left 1, exponent-1.
  - Else go to DONE.
  - A sum of exactly 0 gives result +0 (0x000) with no flags.
- Exponent limits, checked on every NORM update:
  - Exponent >15: result = {sign,1111,1111111}, out_ovf=1, go to DONE.
  - Exponent <1: result = 0x000, out_unf=1, go to DONE.
- DONE: out_valid=1 with out_z and flags held stable. On out_ready=1, go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- Latency from the accept edge to out_valid high = d + s + 3, where d = alignment shifts and s = normalisation shifts. With d=s=0 the latency is 3.
- busy = (state ≠ IDLE).
- Flags clear when the next operation is accepted.

Optional Feature:
FPADD_FAST_ALIGN_EN
- Defined: ALIGN is a single cycle using a barrel shift by d. Latency = (d>0 ? 1 : 0) + s + 3.
- Undefined: one bit per cycle, as described above.
- The result value is identical in both builds.

Test Plan:
- 0x380 + 0x380 (1.0+1.0), out_ready=1: out_z=0x400, no flags, out_valid 4 cycles after accept.
- 0x380 + 0xB80 (1.0 + -1.0): out_z=0x000, no flags, latency 3.
- 0x3C0 + 0x280 (1.5+0.25): out_z=0x3E0, latency 5; latency 4 with FPADD_FAST_ALIGN_EN.
- 0x7FF + 0x7FF: out_z=0x7FF, out_ovf=1. 0x080 + 0x881: out_z=0x000, out_unf=1.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and out_z stay stable and in_ready stays 0. After out_ready=1, in_ready=1 the next cycle.
- Pull reset_n low during ALIGN of 0x3C0+0x280: the next cycle is IDLE with all outputs at reset values. A new 0x380+0x380 then yields 0x400.
